cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/dump sequencer for the 16-bit CPU `top`.
- On a start pulse it holds the core in reset, releases it, and watches the fetched instruction for either halt encoding.
- After a halt it drains the pipeline, takes the data-memory port away from the core, and scans all 65536 words.
- Each nonzero word is streamed out as an (address, data) beat over a valid/ready interface.
- It replaces bench-side halt polling and memory dumping with synthesizable hardware.

## Interface
Parameters:
- RESET_CYCLES, 4, cycles the core is held in reset after start
- DRAIN_CYCLES, 10, cycles waited after halt before taking the memory port
- HALT_OP0, 16'hE000, first halt encoding
- HALT_OP1, 16'hE7FF, second halt encoding
- WDOG_CYCLES, 65535, RUN-cycle limit (used only with RUN_WATCHDOG_EN)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin run; honored only in IDLE or DONE
- instr  in  16  instruction currently in the core's decode stage
- cpu_reset  out  1  active-high reset to the core
- mem_sel  out  1  1 = controller owns the data-memory read port
- mem_rd_en  out  1  read strobe
- mem_addr  out  16  read address
- mem_rd_data  in  16  read data, valid the cycle after mem_rd_en
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  sink accepts beat
- dump_addr  out  16  address of beat
- dump_data  out  16  nonzero memory word
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- timeout  out  1  run ended by watchdog; sticky until next start

## Operation
- States and transitions:
  - IDLE: → RESET on start.
  - RESET: → RUN after RESET_CYCLES cycles.
  - RUN: → DRAIN on halt (or watchdog).
  - DRAIN: → SCAN_RD after DRAIN_CYCLES cycles.
  - SCAN_RD: → SCAN_CHK.
  - SCAN_CHK: → OUT if word nonzero; otherwise → SCAN_RD with addr+1, or → DONE if addr==16'hFFFF.
  - OUT: on dump_valid&&dump_ready → SCAN_RD with addr+1, or → DONE if addr==16'hFFFF.
  - DONE: → RESET on start.
- cpu_reset:
  - 1 in IDLE, RESET, SCAN_RD, SCAN_CHK, OUT and DONE.
  - 0 in RUN and DRAIN.
  - Data memory is not affected by cpu_reset.
- Halt detection: instr is compared against HALT_OP0/HALT_OP1 only in RUN. Any match in other states is ignored.
- mem_sel: 1 from SCAN_RD through DONE; 0 otherwise.
- Scan:
  - The address counter is 16-bit, starts at 0, and never wraps.
  - 16'hFFFF is the terminal address, detected explicitly.
  - mem_rd_data is registered at the end of SCAN_CHK and zero-tested; zero words produce no beat.
- start in DONE clears done and timeout and restarts the whole run.
- Reset values: cpu_reset=1 and state=IDLE. All of the following are 0: mem_sel, mem_rd_en, mem_addr, dump_valid, dump_addr, dump_data, busy, done, timeout, all counters.

## Timing
- All outputs are registered.
- start sampled high at edge t:
  - cpu_reset stays 1 for RESET_CYCLES cycles.
  - cpu_reset falls at edge t+1+RESET_CYCLES (RUN entry).
- Halt matched at edge e:
  - DRAIN occupies cycles e+1 .. e+DRAIN_CYCLES.
  - At edge e+1+DRAIN_CYCLES: mem_sel=1, mem_rd_en=1, mem_addr=0.
- Read handshake:
  - mem_rd_en is high only in SCAN_RD, for exactly 1 cycle per address.
  - Data is sampled one cycle later.
  - Zero word: 2 cycles per address. Full 65536-word all-zero scan: 131072 cycles.
- Dump handshake:
  - dump_valid rises on the edge entering OUT.
  - dump_addr/dump_data stay stable until the beat transfers on an edge with valid&&ready.
  - dump_valid is 0 in the cycle after transfer. There are no back-to-back beats.
- Asynchronous reset at any point (including mid-OUT or mid-scan):
  - All outputs take reset values immediately.
  - Any partial beat is dropped.

## Configuration
- RUN_WATCHDOG_EN defined:
  - A RUN-cycle counter clears on RUN entry.
  - When it reaches WDOG_CYCLES without a halt, the block enters DRAIN and sets timeout=1; the scan proceeds normally.
- RUN_WATCHDOG_EN undefined:
  - No counter is built; timeout is tied to 0.
  - RUN exits only on a halt encoding.

## Test plan
- Reset/idle: hold reset low, then release with no start → cpu_reset=1, all other outputs 0, busy=0 indefinitely.
- Normal run:
  - Program writes mem[1]=16'h1234 and mem[5]=16'hABCD, then executes 16'hE000.
  - Required: exactly two beats, (1,16'h1234) then (5,16'hABCD); done=1 after address 16'hFFFF; timeout=0.
- Backpressure: hold dump_ready=0 for 5 cycles during a beat → dump_valid/addr/data unchanged; no beat skipped or duplicated.
- Halt filtering:
  - Drive 16'hE7FF on instr during RESET → ignored.
  - Drive 16'hE7FF in RUN → DRAIN entered next edge; mem_sel rises exactly DRAIN_CYCLES+1 cycles after the match.
- All-zero memory: halt immediately → zero beats; done rises exactly 131072 cycles after mem_sel rises.
- Watchdog and async reset:
  - With RUN_WATCHDOG_EN and WDOG_CYCLES=100, no halt → timeout=1 and scan completes.
  - Without the macro → still in RUN at cycle 1000.
  - Assert reset mid-OUT → outputs at reset values in the same cycle.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/dump sequencer for the 16-bit CPU core.
// Holds the core in reset after a start pulse, lets it run until a halt
// encoding reaches decode, drains the pipeline, then takes over the
// data-memory read port and streams every nonzero word as an
// (address, data) beat on a valid/ready interface.
// Optional feature: define RUN_WATCHDOG_EN to end runs that exceed
// WDOG_CYCLES cycles in RUN and flag them with timeout.
module cpu_run_ctrl #(
    parameter int          RESET_CYCLES = 4,
    parameter int          DRAIN_CYCLES = 10,
    parameter logic [15:0] HALT_OP0     = 16'hE000,
    parameter logic [15:0] HALT_OP1     = 16'hE7FF,
    parameter int          WDOG_CYCLES  = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        cpu_reset,
    output logic        mem_sel,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rd_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [15:0] dump_addr,
    output logic [15:0] dump_data,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_SCAN_RD,
        S_SCAN_CHK,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_ADDR = 16'hFFFF;

    state_t      state;
    logic [15:0] cnt;
    logic        halt_hit;
    logic        wdog_hit;

    assign halt_hit = (instr == HALT_OP0) || (instr == HALT_OP1);

`ifdef RUN_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WDOG_W-1:0] wdog_cnt;
    assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
    assign wdog_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Registered status flags for the state being entered:
    // {cpu_reset, mem_sel, busy, done}
    function automatic logic [3:0] flags(input state_t s);
        logic [3:0] f;
        f = 4'b1000;
        case (s)
            S_IDLE:     f = 4'b1000;
            S_RESET:    f = 4'b1010;
            S_RUN:      f = 4'b0010;
            S_DRAIN:    f = 4'b0010;
            S_SCAN_RD:  f = 4'b1110;
            S_SCAN_CHK: f = 4'b1110;
            S_OUT:      f = 4'b1110;
            S_DONE:     f = 4'b1101;
            default:    f = 4'b1000;
        endcase
        return f;
    endfunction

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            {cpu_reset, mem_sel, busy, done} <= 4'b1000;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
`ifdef RUN_WATCHDOG_EN
            wdog_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            // The read strobe is a single-cycle pulse issued on SCAN_RD entry
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RESET;
                        {cpu_reset, mem_sel, busy, done} <= flags(S_RESET);
                        cnt      <= '0;
                        mem_addr <= '0;
`ifdef RUN_WATCHDOG_EN
                        timeout  <= 1'b0;
`endif
                    end
                end
                S_RESET: begin
                    if (cnt == 16'(RESET_CYCLES)) begin
                        state <= S_RUN;
                        {cpu_reset, mem_sel, busy, done} <= flags(S_RUN);
`ifdef RUN_WATCHDOG_EN
                        wdog_cnt <= '0;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RUN: begin
`ifdef RUN_WATCHDOG_EN
                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    if (!halt_hit && wdog_hit) timeout <= 1'b1;
`endif
                    // A real halt wins over a watchdog expiry on the same edge
                    if (halt_hit || wdog_hit) begin
                        state <= S_DRAIN;
                        {cpu_reset, mem_sel, busy, done} <= flags(S_DRAIN);
                        cnt   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (cnt == 16'(DRAIN_CYCLES)) begin
                        state     <= S_SCAN_RD;
                        {cpu_reset, mem_sel, busy, done} <= flags(S_SCAN_RD);
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SCAN_RD: begin
                    state <= S_SCAN_CHK;
                    {cpu_reset, mem_sel, busy, done} <= flags(S_SCAN_CHK);
                end
                S_SCAN_CHK: begin
                    if (mem_rd_data != 16'd0) begin
                        state      <= S_OUT;
                        {cpu_reset, mem_sel, busy, done} <= flags(S_OUT);
                        dump_valid <= 1'b1;
                        dump_addr  <= mem_addr;
                        dump_data  <= mem_rd_data;
                    end else if (mem_addr == LAST_ADDR) begin
                        state <= S_DONE;
                        {cpu_reset, mem_sel, busy, done} <= flags(S_DONE);
                    end else begin
                        state     <= S_SCAN_RD;
                        {cpu_reset, mem_sel, busy, done} <= flags(S_SCAN_RD);
                        mem_addr  <= mem_addr + 16'd1;
                        mem_rd_en <= 1'b1;
                    end
                end
                S_OUT: begin
                    // dump_valid is high throughout OUT, so ready alone completes the beat
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (mem_addr == LAST_ADDR) begin
                            state <= S_DONE;
                            {cpu_reset, mem_sel, busy, done} <= flags(S_DONE);
                        end else begin
                            state     <= S_SCAN_RD;
                            {cpu_reset, mem_sel, busy, done} <= flags(S_SCAN_RD);
                            mem_addr  <= mem_addr + 16'd1;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    {cpu_reset, mem_sel, busy, done} <= flags(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: timeline-based reference model, data memory
// model, beat capture and directed scenarios with randomized filler.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

    localparam int          RC = 4;
    localparam int          DC = 10;
    localparam int          WD = 100;
    localparam logic [15:0] H0 = 16'hE000;
    localparam logic [15:0] H1 = 16'hE7FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        cpu_reset, mem_sel, mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data = 16'd0;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [15:0] dump_addr, dump_data;
    logic        busy, done, timeout;

    logic [15:0] mem [0:65535];
    logic [15:0] got_a [$];
    logic [15:0] got_d [$];

    int checks = 0;
    int errors = 0;
    bit rdy_force = 1'b1;
    bit rdy_val   = 1'b0;

    cpu_run_ctrl #(
        .RESET_CYCLES(RC),
        .DRAIN_CYCLES(DC),
        .HALT_OP0(H0),
        .HALT_OP1(H1),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .instr(instr),
        .cpu_reset(cpu_reset),
        .mem_sel(mem_sel),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr(dump_addr),
        .dump_data(dump_data),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Beat capture on every completed handshake
    always @(posedge clk) begin
        if (reset && dump_valid && dump_ready) begin
            got_a.push_back(dump_addr);
            got_d.push_back(dump_data);
        end
    end

    // ---------------- reference model (timeline of edge numbers) ----------------
    int  cyc = 0;
    bit  m_act = 0, m_halted = 0, m_scan = 0, m_out = 0, m_fin = 0, m_to = 0, m_fresh = 1;
    int  t_run = 0, t_scan = 0, seg = 0, cur = 0;
    logic        e_cr = 1'b1, e_ms = 1'b0, e_rd = 1'b0, e_dv = 1'b0;
    logic        e_busy = 1'b0, e_done = 1'b0, e_to = 1'b0;
    logic [15:0] e_ma = 16'd0, e_da = 16'd0, e_dd = 16'd0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_act = 0; m_halted = 0; m_scan = 0; m_out = 0;
                m_fin = 0; m_to = 0; m_fresh = 1;
            end else begin
                bit adv;
                cyc++;
                adv = 0;
                if (!m_act) begin
                    if (start) begin
                        m_act = 1; m_fin = 0; m_to = 0; m_fresh = 0;
                        m_halted = 0; m_scan = 0; m_out = 0;
                        t_run = cyc + 1 + RC;
                    end
                end else if (!m_halted) begin
                    if (cyc > t_run && (instr == H0 || instr == H1)) begin
                        m_halted = 1; t_scan = cyc + 1 + DC;
                    end
`ifdef RUN_WATCHDOG_EN
                    else if (cyc == t_run + WD) begin
                        m_halted = 1; m_to = 1; t_scan = cyc + 1 + DC;
                    end
`endif
                end else if (!m_scan) begin
                    if (cyc == t_scan) begin
                        m_scan = 1; cur = 0; seg = cyc;
                    end
                end else begin
                    if (!m_out && cyc == seg + 2) begin
                        if (mem[cur] != 16'd0) m_out = 1;
                        else adv = 1;
                    end else if (m_out && dump_ready) begin
                        m_out = 0; adv = 1;
                    end
                    if (adv) begin
                        if (cur == 65535) begin
                            m_act = 0; m_scan = 0; m_fin = 1;
                        end else begin
                            cur++; seg = cyc;
                        end
                    end
                end
            end
            // Expected outputs for the cycle that follows
            e_cr = 1'b1; e_ms = 1'b0; e_rd = 1'b0; e_dv = 1'b0;
            e_busy = 1'b0; e_done = 1'b0; e_to = m_to;
            e_ma = m_fresh ? 16'd0 : 16'(cur);
            e_da = m_fresh ? 16'd0 : 16'(cur);
            e_dd = m_fresh ? 16'd0 : mem[16'(cur)];
            if (m_fin) begin
                e_ms = 1'b1; e_done = 1'b1;
            end else if (m_act) begin
                e_busy = 1'b1;
                if (m_scan) begin
                    e_ms = 1'b1;
                    e_rd = (cyc == seg) && !m_out;
                    e_dv = m_out;
                end else if (cyc >= t_run) begin
                    e_cr = 1'b0;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic summary_and_finish();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic compare_cycle();
        bit bad;
        bad = 0;
        bad |= (cpu_reset !== e_cr) || (mem_sel !== e_ms) || (mem_rd_en !== e_rd);
        bad |= (dump_valid !== e_dv) || (busy !== e_busy) || (done !== e_done);
        bad |= (timeout !== e_to);
        if (e_rd || m_fresh) bad |= (mem_addr !== e_ma);
        if (e_dv || m_fresh) bad |= (dump_addr !== e_da) || (dump_data !== e_dd);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cycle_check t=%0t: got cr=%b ms=%b rd=%b ma=%h dv=%b da=%h dd=%h busy=%b done=%b to=%b, required cr=%b ms=%b rd=%b ma=%h dv=%b da=%h dd=%h busy=%b done=%b to=%b",
                     $time, cpu_reset, mem_sel, mem_rd_en, mem_addr, dump_valid, dump_addr, dump_data, busy, done, timeout,
                     e_cr, e_ms, e_rd, e_ma, e_dv, e_da, e_dd, e_busy, e_done, e_to);
        end
    endtask

    // One clock: compare outputs at the falling edge, then drive ready
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        if (errors > 50) begin
            $display("FAIL abort: %0d errors, stopping early", errors);
            summary_and_finish();
        end
        dump_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
    endtask

    function automatic logic [15:0] rand_nonhalt();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == H0 || v == H1) v = 16'h0001;
        return v;
    endfunction

    // Pulse start with a halt code on instr (must be ignored in RESET);
    // returns cycles until cpu_reset falls.
    task automatic start_run(output int n);
        instr = H1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (cpu_reset && n < 50) begin
            tick();
            n++;
        end
        instr = rand_nonhalt();
    endtask

    // Present a halt encoding for one edge; returns cycles until mem_sel rises
    task automatic halt_run(input logic [15:0] op, output int n);
        instr = op;
        tick();
        instr = H0;
        n = 0;
        while (!mem_sel && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 140000) begin
            tick();
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int b0;
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();

        // Idle after reset with no start
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mem_sel", 32'(mem_sel), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_dump_valid", 32'(dump_valid), 32'd0);

        // Normal run with two nonzero words and backpressure on the first beat
        mem[1] = 16'h1234;
        mem[5] = 16'hABCD;
        b0 = got_a.size();
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        start_run(n);
        chk("reset_len", 32'(n), 32'(RC + 1));
        repeat (8) begin
            instr = rand_nonhalt();
            tick();
        end
        halt_run(H1, n);
        chk("halt_to_mem_sel", 32'(n), 32'(DC + 1));
        n = 0;
        while (!dump_valid && n < 50) begin
            tick();
            n++;
        end
        chk("first_beat_seen", 32'(dump_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(dump_valid), 32'd1);
            chk("bp_addr", 32'(dump_addr), 32'h0001);
            chk("bp_data", 32'(dump_data), 32'h1234);
            tick();
        end
        rdy_force = 1'b0;
        wait_done(n);
        chk("normal_done", 32'(done), 32'd1);
        chk("normal_timeout", 32'(timeout), 32'd0);
        chk("normal_beat_count", 32'(got_a.size() - b0), 32'd2);
        if (got_a.size() - b0 == 2) begin
            chk("beat0_addr", 32'(got_a[b0]), 32'h0001);
            chk("beat0_data", 32'(got_d[b0]), 32'h1234);
            chk("beat1_addr", 32'(got_a[b0 + 1]), 32'h0005);
            chk("beat1_data", 32'(got_d[b0 + 1]), 32'hABCD);
        end

        // All-zero memory, restarted from DONE, halt at once
        mem[1] = 16'd0;
        mem[5] = 16'd0;
        b0 = got_a.size();
        start_run(n);
        chk("restart_clears_done", 32'(done), 32'd0);
        halt_run(H0, n);
        chk("zero_mem_sel_seen", 32'(mem_sel), 32'd1);
        wait_done(n);
        chk("zero_scan_len", 32'(n), 32'd131072);
        chk("zero_beat_count", 32'(got_a.size() - b0), 32'd0);

        // Run without any halt encoding
        start_run(n);
        for (int k = 0; k < 1000; k++) begin
            instr = rand_nonhalt();
            tick();
        end
`ifdef RUN_WATCHDOG_EN
        wait_done(n);
        chk("wdog_done", 32'(done), 32'd1);
        chk("wdog_timeout", 32'(timeout), 32'd1);
`else
        chk("no_wdog_still_run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("no_wdog_still_run_busy", 32'(busy), 32'd1);
        chk("no_wdog_mem_sel", 32'(mem_sel), 32'd0);
        chk("no_wdog_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif

        // Asynchronous reset while a beat is held in OUT
        mem[3] = 16'h5555;
        b0 = got_a.size();
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        start_run(n);
        halt_run(H0, n);
        n = 0;
        while (!dump_valid && n < 50) begin
            tick();
            n++;
        end
        chk("out_beat_seen", 32'(dump_valid), 32'd1);
        chk("out_beat_addr", 32'(dump_addr), 32'h0003);
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("arst_outputs", {22'd0, mem_sel, mem_rd_en, dump_valid, busy, done, timeout, 4'd0}, 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("arst_dump_addr", 32'(dump_addr), 32'd0);
        chk("arst_dump_data", 32'(dump_data), 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        rdy_force = 1'b0;
        repeat (10) tick();
        chk("arst_no_beat", 32'(got_a.size() - b0), 32'd0);
        chk("arst_idle_busy", 32'(busy), 32'd0);

        summary_and_finish();
    end

endmodule
